// File: rtl/serial_compare_ctrl.sv
// Bit-serial MSB-first magnitude comparator controller: one bit per clock,
// early exit on the first differing bit, unsigned or two's-complement per op.
module serial_compare_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic signed [WIDTH-1:0] a_sh;
    logic signed [WIDTH-1:0] b_sh;
    logic                   sgn;
    logic [CNT_W-1:0]       cnt;

    logic load;
    logic shift;
    logic fin;
    logic res_lt;
    logic res_gt;
    logic res_eq;
    logic abit;
    logic bbit;
    logic first_bit;

    // On a differing bit, A is greater when its bit is 1, except at the sign
    // bit of a signed compare where a 1 marks the negative (smaller) operand.
    function automatic logic decide_gt(input logic a_bit, input logic signed_op,
                                       input logic sign_pos);
        return a_bit ^ (signed_op & sign_pos);
    endfunction

    assign abit      = a_sh[WIDTH-1];
    assign bbit      = b_sh[WIDTH-1];
    assign first_bit = (cnt == CNT_MAX);
    assign busy      = (state == COMPARE);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        fin       = 1'b0;
        res_lt    = 1'b0;
        res_gt    = 1'b0;
        res_eq    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = COMPARE;
                end
            end
            COMPARE: begin
                if (abit != bbit) begin
                    fin       = 1'b1;
                    res_gt    = decide_gt(abit, sgn, first_bit);
                    res_lt    = ~decide_gt(abit, sgn, first_bit);
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    fin       = 1'b1;
                    res_eq    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    shift     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            sgn   <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
            lt    <= 1'b0;
            gt    <= 1'b0;
            eq    <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= fin;
            if (load) begin
                a_sh <= a;
                b_sh <= b;
                sgn  <= is_signed;
                cnt  <= CNT_MAX;
                lt   <= 1'b0;
                gt   <= 1'b0;
                eq   <= 1'b0;
            end else if (shift) begin
                a_sh <= a_sh <<< 1;
                b_sh <= b_sh <<< 1;
                cnt  <= cnt - 1'b1;
            end else if (fin) begin
                lt <= res_lt;
                gt <= res_gt;
                eq <= res_eq;
            end
        end
    end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed-vector bench for serial_compare_ctrl at WIDTH=8.
module tb_serial_compare_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             lt;
    logic             gt;
    logic             eq;

    int checks = 0;
    int errors = 0;

    serial_compare_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .lt        (lt),
        .gt        (gt),
        .eq        (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic d, input logic l,
                           input logic g, input logic e);
        chk({tag, ".done"}, done, d);
        chk({tag, ".lt"},   lt,   l);
        chk({tag, ".gt"},   gt,   g);
        chk({tag, ".eq"},   eq,   e);
    endtask

    // start at E0, expect the decision at edge E(ncyc), then done drops and result holds
    task automatic run_cmp(input string tag, input logic [WIDTH-1:0] va,
                           input logic [WIDTH-1:0] vb, input logic sg, input int ncyc,
                           input logic l, input logic g, input logic e);
        a = va; b = vb; is_signed = sg; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".busy0"}, busy, 1'b1);
        chk_res({tag, ".clr"}, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= ncyc; k++) begin
            tick();
            if (k < ncyc) begin
                chk({tag, ".busy"}, busy, 1'b1);
                chk({tag, ".early"}, done, 1'b0);
            end
        end
        chk({tag, ".idle"}, busy, 1'b0);
        chk_res(tag, 1'b1, l, g, e);
        tick();
        chk_res({tag, ".hold"}, 1'b0, l, g, e);
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int done_seen;
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        tick(); tick();
        chk("rst.busy", busy, 1'b0);
        chk_res("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        run_cmp("eq5a",    8'h5A, 8'h5A, 1'b0, 8, 1'b0, 1'b0, 1'b1);
        run_cmp("u80_7f",  8'h80, 8'h7F, 1'b0, 1, 1'b0, 1'b1, 1'b0);
        run_cmp("s80_7f",  8'h80, 8'h7F, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        run_cmp("sfe_fd",  8'hFE, 8'hFD, 1'b1, 7, 1'b0, 1'b1, 1'b0);
        run_cmp("u12_13",  8'h12, 8'h13, 1'b0, 8, 1'b1, 1'b0, 1'b0);
        run_cmp("s01_ff",  8'h01, 8'hFF, 1'b1, 1, 1'b0, 1'b1, 1'b0);
        run_cmp("u01_ff",  8'h01, 8'hFF, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        run_cmp("seq_neg", 8'h9C, 8'h9C, 1'b1, 8, 1'b0, 1'b0, 1'b1);

        // start while busy is ignored; start in the done cycle is accepted
        a = 8'h12; b = 8'h13; is_signed = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a = 8'h00; b = 8'hFF; is_signed = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign.busy", busy, 1'b1);
        for (int k = 4; k <= 7; k++) begin
            tick();
            chk("ign.early", done, 1'b0);
        end
        tick();
        chk_res("ign", 1'b1, 1'b1, 1'b0, 1'b0);
        a = 8'h40; b = 8'h20; is_signed = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b.busy", busy, 1'b1);
        chk_res("b2b.clr", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("b2b.e1", done, 1'b0);
        tick();
        chk_res("b2b", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();

        // asynchronous reset in the middle of a compare
        a = 8'h5A; b = 8'h5A; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("pre_rst.busy", busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst.busy", busy, 1'b0);
        chk_res("arst", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done) done_seen++;
        end
        chk("post_rst.nodone", done_seen, 0);
        chk("post_rst.busy", busy, 1'b0);
        run_cmp("post_rst", 8'h5A, 8'h5A, 1'b0, 8, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_compare_ctrl.md
Name: serial_compare_ctrl

Overview:
Sequencing controller for the 1-bit comparator slice. It compares two WIDTH-bit operands bit-serially, MSB first, one bit per clock, using a single lt/gt/eq bit-compare, and exits early on the first differing bit. It sits between a requester issuing start/operands and downstream logic that consumes a registered lt/gt/eq result with a done strobe. Unsigned or two's-complement comparison is selected per operation.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a comparison; sampled only when busy=0
is_signed  input  1  1 = two's-complement compare, 0 = unsigned; latched with start
a  input  WIDTH  operand A; latched with start
b  input  WIDTH  operand B; latched with start
busy  output  1  high while a comparison is in progress
done  output  1  single-cycle strobe: result valid and just updated
lt  output  1  registered result A < B
gt  output  1  registered result A > B
eq  output  1  registered result A == B

Behaviour:
- Reset (async, any time, including mid-compare): state IDLE; busy, done, lt, gt, eq all 0; shift registers and bit counter cleared. After reset release, no done until a new start is accepted.
- States: IDLE, COMPARE. There is no separate DONE state; done is registered and asserted in the cycle after the deciding edge, while the FSM is already in IDLE.
- IDLE: busy=0. On an edge with start=1, called E0: latch a, b, is_signed into shift registers and sign flag; load the bit counter with WIDTH-1; clear lt/gt/eq to 0; go to COMPARE.
- COMPARE: busy=1. Each edge evaluates the current MSB of the shift registers (abit, bbit):
  - abit==bbit and the counter is not 0: shift both registers left by 1, decrement the counter, stay in COMPARE.
  - abit!=bbit: decide immediately. Unsigned, or any bit other than the first (sign) bit: abit=1 gives gt=1, otherwise lt=1. Signed and first bit: the sense is inverted, so abit=1 gives lt=1. Set done=1 and go to IDLE.
  - abit==bbit and the counter is 0: eq=1, done=1, go to IDLE.
- Latency: a difference at bit index i (WIDTH-1 = MSB) is decided at edge E(WIDTH-i). done is high for exactly one cycle after that edge. Worst case (equal, or differing only at bit 0) is done after E(WIDTH).
- Exactly one of lt/gt/eq is 1 from the done cycle until the next accepted start. All three are 0 while busy.
- start while busy=1 is ignored: no effect on operands, the counter or the result.
- start in the done cycle (busy=0) is accepted. Results clear at that edge, giving back-to-back operation with no dead cycle.
- a, b and is_signed changing after E0 have no effect on the operation in flight.

Test Plan:
- WIDTH=8, unsigned, a=0x5A, b=0x5A, start at E0 -> busy for E1..E8; done=1, eq=1, lt=gt=0 in the cycle after E8; done=0 in the next cycle, eq held.
- Unsigned, a=0x80, b=0x7F -> decided at E1: done=1, gt=1 in the cycle after E1, busy=0.
- Signed, a=0x80, b=0x7F -> decided at E1: lt=1 (-128 < 127). Signed a=0xFE, b=0xFD -> gt=1 at E7 (-2 > -3).
- Unsigned, a=0x12, b=0x13 -> differ only at bit 0: lt=1, done after E8.
- Pulse start with a=0x00, b=0xFF at E3 during a compare started with 0x12/0x13 -> ignored; the original result lt=1 at E8. Assert start in that done cycle with a=0x40, b=0x20 -> accepted, lt cleared, gt=1 after E2 of the new operation.
- Assert rst at E4 of a compare of 0x5A/0x5A -> busy, done, lt, gt, eq all 0 immediately (asynchronous). After release there is no done, and the next start completes normally.
